// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR sink-side blocks.
package fir_pkg;

  localparam int FIR_DW  = 18;  // FIR output sample width
  localparam int DECIM_W = 8;   // decimation factor field width

  // Ceiling log2, used to size FIFO pointers from the depth.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO: head_data is combinationally mem[rd_ptr].
// Pointers and count reset asynchronously; storage is not reset.
module fir_sync_fifo #(
  parameter int DW    = 18,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH = 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/fir_output_collector.sv
// Collects the FIR output stream, decimates it, buffers kept samples and
// back-pressures the FIR through its clk_ena stall input.
module fir_output_collector
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = 8,
  parameter int AW    = clog2(DEPTH),
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fir_o_valid,
  input  logic [DW-1:0]      fir_o_out,
  output logic               fir_clk_ena,
  input  logic [DECIM_W-1:0] decim_m,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_data,
  output logic [AW:0]        fifo_level,
  output logic [CNTW-1:0]    sample_cnt
);

  logic [DECIM_W-1:0] phase_q, phase_d;
  logic [CNTW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [DECIM_W-1:0] m_eff;
  logic               consume, keep, pop;
  logic [DW-1:0]      head_data;
  logic [AW:0]        count;
  logic               full, empty;

  // Stall depends only on registered occupancy; a pop never reopens a full
  // FIFO in the same cycle, so the FIR resumes one cycle after the pop.
  assign fir_clk_ena = ~full;
  assign consume     = fir_clk_ena & fir_o_valid;
  assign m_eff       = (decim_m == '0) ? DECIM_W'(1) : decim_m;
  assign keep        = consume & (phase_q == '0);
  assign pop         = m_valid & m_ready;

  // Decimation phase and pushed-sample counter next-state. The >= compare
  // lets the phase wrap cleanly if decim_m shrinks mid-stream.
  always_comb begin
    phase_d      = phase_q;
    sample_cnt_d = sample_cnt_q;
    if (consume) phase_d = (phase_q >= m_eff - DECIM_W'(1)) ? '0 : phase_q + DECIM_W'(1);
    if (keep)    sample_cnt_d = sample_cnt_q + CNTW'(1);
  end

  // Phase and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      sample_cnt_q <= '0;
    end else begin
      phase_q      <= phase_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  fir_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data (fir_o_out),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign m_valid    = ~empty;
  assign m_data     = m_valid ? head_data : '0;
  assign fifo_level = count;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fir_output_collector.sv
// Scoreboard bench: a FIR source model feeds samples, a reference model
// decides which are kept and queues them; pops are checked in order.
module tb_fir_output_collector;

  localparam int DW = 18;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
  } src_t;

  logic          clk, reset;
  logic          fir_o_valid;
  logic [DW-1:0] fir_o_out;
  logic          fir_clk_ena;
  logic [7:0]    decim_m;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic [3:0]    fifo_level;
  logic [15:0]   sample_cnt;

  fir_output_collector dut (
    .clk         (clk),
    .reset       (reset),
    .fir_o_valid (fir_o_valid),
    .fir_o_out   (fir_o_out),
    .fir_clk_ena (fir_clk_ena),
    .decim_m     (decim_m),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .fifo_level  (fifo_level),
    .sample_cnt  (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk, n_pass;
  src_t          src_q[$];
  logic [DW-1:0] exp_q[$];
  int            mph, mcount;
  logic [15:0]   mcnt;
  logic          rdy;
  int            cyc_n, max_lvl;
  int            pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_src(input logic v, input logic [DW-1:0] d);
    src_t s;
    s.v = v; s.d = d;
    src_q.push_back(s);
  endtask

  task automatic clear_model();
    src_q.delete(); exp_q.delete(); pop_cyc.delete();
    mph = 0; mcount = 0; mcnt = '0;
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_mvalid"}, m_valid, 0);
    chk({tag, "_mdata"},  m_data, 0);
    chk({tag, "_level"},  fifo_level, 0);
    chk({tag, "_cnt"},    sample_cnt, 0);
    chk({tag, "_ena"},    fir_clk_ena, 1);
  endtask

  // One cycle, entered at a falling edge: drive, settle, check against the
  // model, advance the model for the coming rising edge.
  task automatic cyc();
    int meff;
    logic ena, mpop, cons, keep;
    if (src_q.size() > 0) begin
      fir_o_valid = src_q[0].v;
      fir_o_out   = src_q[0].d;
    end else begin
      fir_o_valid = 1'b0;
      fir_o_out   = '0;
    end
    m_ready = rdy;
    #1;
    ena  = (mcount != 8);
    mpop = (mcount != 0) && rdy;
    chk("level",  fifo_level, mcount);
    chk("ena",    fir_clk_ena, ena);
    chk("mvalid", m_valid, (mcount != 0));
    chk("cnt",    sample_cnt, mcnt);
    if (mcount == 0) chk("mdata_idle", m_data, 0);
    if (fifo_level > max_lvl) max_lvl = fifo_level;
    if (mpop) begin
      if (exp_q.size() == 0) chk("pop_avail", exp_q.size(), 1);
      else chk("pop_data", m_data, exp_q.pop_front());
      pop_cyc.push_back(cyc_n);
    end
    cons = ena && fir_o_valid;
    keep = cons && (mph == 0);
    if (cons) begin
      meff = (decim_m == 0) ? 1 : int'(decim_m);
      mph  = (mph >= meff - 1) ? 0 : mph + 1;
    end
    if (keep) begin
      exp_q.push_back(fir_o_out);
      mcnt = mcnt + 16'd1;
    end
    mcount = mcount + (keep ? 1 : 0) - (mpop ? 1 : 0);
    if (ena && src_q.size() > 0) void'(src_q.pop_front());
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && c < maxc) begin
      cyc();
      c++;
    end
    chk("drain", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    fir_o_valid = 1'b0;
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start;
    n_chk = 0; n_pass = 0; cyc_n = 0;
    rdy = 1'b1; m_ready = 1'b1; decim_m = 8'd1;
    fir_o_valid = 1'b0; fir_o_out = '0;
    reset = 1'b1;
    clear_model();
    #2;
    rst_checks("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic pass-through, one-cycle latency
    decim_m = 8'd1; rdy = 1'b1; max_lvl = 0; pop_cyc.delete();
    push_src(1, 18'd5); push_src(1, 18'(-3)); push_src(1, 18'd7);
    start = cyc_n;
    drain(20);
    chk("t1_maxlvl", max_lvl, 1);
    chk("t1_cnt", sample_cnt, 3);
    chk("t1_lat0", pop_cyc[0] - start, 1);
    chk("t1_lat2", pop_cyc[2] - start, 3);

    // 2: back-pressure fills FIFO, FIR stalls, then drains in order
    rdy = 1'b0;
    for (int i = 1; i <= 10; i++) push_src(1, 18'(i));
    repeat (14) cyc();
    chk("t2_level", fifo_level, 8);
    chk("t2_ena", fir_clk_ena, 0);
    chk("t2_held", src_q.size(), 2);
    rdy = 1'b1;
    drain(40);

    // 3: decimate by 3
    do_reset();
    decim_m = 8'd3;
    for (int i = 0; i <= 8; i++) push_src(1, 18'(i));
    drain(40);
    chk("t3_cnt", sample_cnt, 3);

    // 4: decim 0 keeps everything; shrink decim 4 -> 2 at phase 3
    decim_m = 8'd0;
    for (int i = 20; i <= 23; i++) push_src(1, 18'(i));
    drain(30);
    chk("t4_cnt0", sample_cnt, 7);
    decim_m = 8'd4;
    for (int i = 30; i <= 32; i++) push_src(1, 18'(i));
    drain(30);
    decim_m = 8'd2;
    for (int i = 33; i <= 37; i++) push_src(1, 18'(i));
    drain(30);
    chk("t4_cnt1", sample_cnt, 10);

    // 5: bubbles do not advance phase
    decim_m = 8'd2;
    push_src(1, 18'd10); push_src(0, 18'd11); push_src(1, 18'd12);
    push_src(0, 18'd13); push_src(1, 18'd14);
    drain(30);
    chk("t5_cnt", sample_cnt, 12);

    // 6: asynchronous reset with data buffered and phase mid-cycle
    do_reset();
    decim_m = 8'd3; rdy = 1'b0;
    for (int i = 0; i < 14; i++) push_src(1, 18'(100 + i));
    repeat (16) cyc();
    chk("t6_level", fifo_level, 5);
    chk("t6_phase", mph, 2);
    #3;
    reset = 1'b1;
    #1;
    rst_checks("t6_async");
    clear_model();
    fir_o_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rdy = 1'b1;
    push_src(1, 18'd50);
    drain(20);
    chk("t6_cnt", sample_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
